// File: rtl/hex_display_scanner.sv
// Multiplexed seven-segment scanner with a frame-synchronous shadow load.
// Optional blink support is compiled in with `define HEX_SCAN_BLINK_EN.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5*NUM_DIGITS-1:0]   digitsIn,
  input  logic                      loadReq,
  output logic                      loadAck,
  input  logic [NUM_DIGITS-1:0]     blankMask,
`ifdef HEX_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blinkMask,
`endif
  output logic [4:0]                codeOut,
  output logic [NUM_DIGITS-1:0]     digitSel,
  output logic                      frameTick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [4:0] BLANK = 5'd31;

  logic [PW-1:0]                cnt, cnt_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic [NUM_DIGITS-1:0][4:0]   shadow, shadow_nxt;
  logic                         adv, boundary, latch;
  logic                         dark_nxt;
  logic [4:0]                   code_nxt;

`ifdef HEX_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          phase_on, phase_on_nxt;
`else
  if (BLINK_FRAMES < 1) begin : g_bad_blink_cfg
  end
`endif

  always_comb begin
    adv      = (cnt == PW'(SCAN_DIV - 1));
    boundary = adv && (idx == IW'(NUM_DIGITS - 1));
    latch    = boundary && loadReq;
    cnt_nxt  = adv ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (adv) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    // outputs are computed from next-state so they change on the same edge as idx
    shadow_nxt = latch ? digitsIn : shadow;
    dark_nxt   = blankMask[idx_nxt];
  end

`ifdef HEX_SCAN_BLINK_EN
  always_comb begin
    fcnt_nxt     = fcnt;
    phase_on_nxt = phase_on;
    if (boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_nxt     = '0;
        phase_on_nxt = ~phase_on;
      end else begin
        fcnt_nxt = fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt     <= '0;
      phase_on <= 1'b1;
    end else begin
      fcnt     <= fcnt_nxt;
      phase_on <= phase_on_nxt;
    end
  end

  always_comb code_nxt = (dark_nxt || (!phase_on_nxt && blinkMask[idx_nxt]))
                         ? BLANK : shadow_nxt[idx_nxt];
`else
  always_comb code_nxt = dark_nxt ? BLANK : shadow_nxt[idx_nxt];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= {NUM_DIGITS{BLANK}};
      codeOut   <= BLANK;
      digitSel  <= ~NUM_DIGITS'(1);
      loadAck   <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      codeOut   <= code_nxt;
      digitSel  <= ~(NUM_DIGITS'(1) << idx_nxt);
      loadAck   <= latch;
      frameTick <= boundary;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scanner bench: table-driven scenario segments plus randomized traffic, all
// checked cycle by cycle against a cycle-count based reference model.
module tb_hex_display_scanner;
  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [5*N-1:0]  digitsIn;
  logic            loadReq;
  logic            loadAck;
  logic [N-1:0]    blankMask;
  logic [4:0]      codeOut;
  logic [N-1:0]    digitSel;
  logic            frameTick;
`ifdef HEX_SCAN_BLINK_EN
  logic [N-1:0]    blinkMask;
`endif

  hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digitsIn(digitsIn), .loadReq(loadReq), .loadAck(loadAck),
    .blankMask(blankMask),
`ifdef HEX_SCAN_BLINK_EN
    .blinkMask(blinkMask),
`endif
    .codeOut(codeOut), .digitSel(digitSel), .frameTick(frameTick));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int k = 0;        // clock edges since reset released
  int frames = 0;   // frame boundaries since reset
  int shadow [N];
  int ack_seen = 0;

  typedef struct {
    logic           rst;
    logic           req;
    logic [5*N-1:0] digits;
    logic [N-1:0]   blank;
    int             ncyc;
    int             acks;
  } seg_t;
  seg_t vec [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  // One clock: advance the model from the rules, then compare all outputs.
  task automatic step();
    int idx, ec, es, ea, et;
    bit brd, on;
    @(posedge clk);
    if (rst) begin
      k = 0; frames = 0; ea = 0; et = 0;
      for (int i = 0; i < N; i++) shadow[i] = 31;
      idx = 0; ec = 31;
    end else begin
      brd = (k % (S*N)) == (S*N - 1);
      k++;
      et = brd ? 1 : 0;
      ea = (brd && loadReq) ? 1 : 0;
      if (brd) frames++;
      if (ea == 1) for (int i = 0; i < N; i++) shadow[i] = int'(digitsIn[5*i +: 5]);
      idx = (k / S) % N;
      on = ((frames / BF) % 2) == 0;
      ec = shadow[idx];
      if (blankMask[idx]) ec = 31;
`ifdef HEX_SCAN_BLINK_EN
      else if (!on && blinkMask[idx]) ec = 31;
`else
      if (!on) ec = ec;
`endif
    end
    es = (~(1 << idx)) & ((1 << N) - 1);
    #1;
    if (loadAck) ack_seen++;
    check("codeOut",   int'(codeOut),   ec);
    check("digitSel",  int'(digitSel),  es);
    check("loadAck",   int'(loadAck),   ea);
    check("frameTick", int'(frameTick), et);
  endtask

  initial begin
    rst = 1'b1; loadReq = 1'b0; digitsIn = '0; blankMask = '0;
`ifdef HEX_SCAN_BLINK_EN
    blinkMask = '0;
`endif
    for (int i = 0; i < N; i++) shadow[i] = 31;

    vec[0]  = '{1'b1, 1'b0, 20'h0, 4'b0000,  2, 0};  // reset state
    vec[1]  = '{1'b0, 1'b0, 20'h0, 4'b0000, 20, 0};  // idle scan, all blank
    vec[2]  = '{1'b0, 1'b1, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 12, 1}; // mid-frame load
    vec[3]  = '{1'b0, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 20, 0};
    vec[4]  = '{1'b0, 1'b1, {5'd9, 5'd9, 5'd9, 5'd9},  4'b0000,  3, 0}; // short pulse
    vec[5]  = '{1'b0, 1'b0, {5'd9, 5'd9, 5'd9, 5'd9},  4'b0000, 10, 0};
    vec[6]  = '{1'b0, 1'b0, 20'h0, 4'b0010, 16, 0};  // blank digit 1
    vec[7]  = '{1'b0, 1'b0, 20'h0, 4'b0000, 16, 0};  // restore
    vec[8]  = '{1'b0, 1'b1, {5'd8, 5'd7, 5'd6, 5'd5}, 4'b0000, 10, 0};
    vec[9]  = '{1'b1, 1'b1, {5'd8, 5'd7, 5'd6, 5'd5}, 4'b0000,  1, 0}; // reset during digit 2
    vec[10] = '{1'b0, 1'b0, {5'd8, 5'd7, 5'd6, 5'd5}, 4'b0000, 20, 0};
    vec[11] = '{1'b0, 1'b1, {5'd8, 5'd7, 5'd6, 5'd5}, 4'b0000, 16, 1}; // re-asserted

    for (int v = 0; v < 12; v++) begin
      rst = vec[v].rst; loadReq = vec[v].req;
      digitsIn = vec[v].digits; blankMask = vec[v].blank;
      ack_seen = 0;
      for (int c = 0; c < vec[v].ncyc; c++) step();
      check($sformatf("seg%0d_acks", v), ack_seen, vec[v].acks);
    end
    rst = 1'b0; loadReq = 1'b0;

`ifdef HEX_SCAN_BLINK_EN
    // blink on digit 0 with data 1,2,3,4 over several blink periods
    digitsIn = {5'd4, 5'd3, 5'd2, 5'd1}; loadReq = 1'b1;
    for (int c = 0; c < S*N; c++) begin
      step();
      if (loadAck) loadReq = 1'b0;
    end
    loadReq = 1'b0; blinkMask = 4'b0001;
    for (int c = 0; c < 8*S*N; c++) step();
`endif

    // randomized traffic: requests held or dropped, live mask changes, rare resets
    for (int c = 0; c < 1500; c++) begin
      if (loadAck && $urandom_range(0, 1) == 0) loadReq = 1'b0;
      else if (!loadReq && $urandom_range(0, 11) == 0) begin
        digitsIn = 20'($urandom());
        loadReq  = 1'b1;
      end else if (loadReq && $urandom_range(0, 19) == 0) loadReq = 1'b0;
      if ($urandom_range(0, 15) == 0) blankMask = 4'($urandom());
`ifdef HEX_SCAN_BLINK_EN
      if ($urandom_range(0, 31) == 0) blinkMask = 4'($urandom());
`endif
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of multiplexed seven-segment digits, range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit is held active, range 2..2^20.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period (used only under REQ-026).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 digitsIn  input  5*NUM_DIGITS  digit codes for the hex driver; digit i occupies bits [5i+4:5i].
REQ-007 loadReq  input  1  request to latch digitsIn; held high until loadAck.
REQ-008 loadAck  output  1  one-cycle pulse confirming digitsIn was latched.
REQ-009 blankMask  input  NUM_DIGITS  bit i set forces digit i blank; sampled live.
REQ-010 codeOut  output  5  code presented to the hex driver; 5'd31 means blank.
REQ-011 digitSel  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-012 frameTick  output  1  one-cycle pulse after each scan wrap.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the "advance cycle" is the cycle in which it equals SCAN_DIV-1.
REQ-014 Scan index SHALL advance by 1 on each advance-cycle edge and wrap from NUM_DIGITS-1 to 0.
REQ-015 Frame boundary = advance cycle with index NUM_DIGITS-1.
REQ-016 codeOut and digitSel SHALL be registered and SHALL reflect the new index on the same edge the index changes.
REQ-017 digitSel SHALL drive exactly one bit low, namely bit index; never zero or multiple bits low.
REQ-018 codeOut SHALL equal the shadow register entry for index unless blankMask[index] is set, in which case it SHALL be 5'd31.
REQ-019 Shadow register (NUM_DIGITS x 5 bits) SHALL update only on the frame-boundary edge when loadReq is high on that cycle.
REQ-020 On that edge loadAck SHALL pulse high for one cycle, and codeOut SHALL already present the newly latched digit 0.
REQ-021 A loadReq deasserted before a frame boundary SHALL produce no latch and no loadAck; digitsIn SHALL be held stable while loadReq is high.
REQ-022 loadReq still high the cycle after loadAck SHALL be treated as a new request, serviced at the next frame boundary.
REQ-023 frameTick SHALL pulse high for one cycle on every frame-boundary edge, coincident with any loadAck.

Reset
REQ-024 While rst is high at a clock edge: prescaler 0, index 0, shadow entries all 5'd31, codeOut 5'd31, digitSel all ones except bit 0 low, loadAck 0, frameTick 0, blink phase "on".
REQ-025 Reset asserted mid-frame or with a pending loadReq SHALL discard the pending request; a request must be re-asserted after reset.

Configuration
REQ-026 With macro HEX_SCAN_BLINK_EN defined: input blinkMask (NUM_DIGITS) SHALL exist, and a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame boundaries. In the "off" phase, digits with blinkMask set SHALL show 5'd31; blankMask has priority.
REQ-027 Without HEX_SCAN_BLINK_EN: no blinkMask port, no blink counter, display never blinks.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset, no load -> codeOut 31 throughout; digitSel sequence 1110,1101,1011,0111 every 4 cycles; frameTick every 16 cycles.
REQ-029 digitsIn={4,3,2,1} (digit 0 = 1), loadReq raised mid-frame -> loadAck and frameTick together at boundary; codeOut 1,2,3,4 from that edge onward.
REQ-030 loadReq pulsed 3 cycles, dropped before boundary -> no loadAck; codeOut unchanged.
REQ-031 After REQ-029 load, blankMask=0010 -> codeOut 1,31,3,4; clearing the mask restores 2 on the next digit-1 slot.
REQ-032 rst high for one cycle during digit 2 with loadReq pending -> next cycle matches REQ-024; no loadAck follows until loadReq is re-asserted.
REQ-033 HEX_SCAN_BLINK_EN, blinkMask=0001, data 1,2,3,4 -> digit 0 shows 1 for 2 frames, then 31 for 2 frames, repeating; other digits steady.
